// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 feedforward convolutional encoder (G0=171, G1=133 octal) with zero-tail termination.
// Optional build macro CONV_ENC_ERR_INJ_EN adds err_mask_i, XORed into each loaded code symbol.
module conv_encoder_k7 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid_i,
   input  logic       in_bit_i,
   input  logic       in_last_i,
   output logic       in_ready_o,
   output logic       out_valid_o,
   output logic [1:0] out_pair_o,
   output logic       out_last_o,
   input  logic       out_ready_i,
`ifdef CONV_ENC_ERR_INJ_EN
   input  logic [1:0] err_mask_i,
`endif
   output logic       busy_o
);

   localparam int unsigned K  = 7;
   localparam int unsigned SW = K - 1;
   localparam int unsigned TW = 3;
   localparam logic [K-1:0] G0 = 7'o171;
   localparam logic [K-1:0] G1 = 7'o133;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] TAIL = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    fsm_q, fsm_d;
   logic [SW-1:0] state_q, state_d;
   logic [TW-1:0] tail_cnt_q, tail_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [1:0]    out_pair_q, out_pair_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;
   logic          armed_q;

   logic          load_ok_c;
   logic          in_ready_c;
   logic          accept_c;
   logic          load_c;
   logic          load_last_c;
   logic          enc_bit_c;
   logic [SW-1:0] enc_state_c;
   logic [K-1:0]  w_c;
   logic [1:0]    sym_c;

   // armed_q keeps in_ready low while in reset and for the first edge after it
   assign load_ok_c  = !out_valid_q || out_ready_i;
   assign in_ready_c = armed_q && load_ok_c && ((fsm_q == IDLE) || (fsm_q == DATA));
   assign accept_c   = in_valid_i && in_ready_c;

   // next-state, encoder datapath and output-stage load
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q;
      out_pair_d  = out_pair_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      load_c      = 1'b0;
      load_last_c = 1'b0;
      enc_bit_c   = 1'b0;
      enc_state_c = state_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (fsm_q)
         IDLE: begin
            enc_state_c = '0;
            if (accept_c) begin
               load_c     = 1'b1;
               enc_bit_c  = in_bit_i;
               busy_d     = 1'b1;
               tail_cnt_d = '0;
               fsm_d      = in_last_i ? TAIL : DATA;
            end
         end
         DATA: begin
            if (accept_c) begin
               load_c    = 1'b1;
               enc_bit_c = in_bit_i;
               if (in_last_i) begin
                  tail_cnt_d = '0;
                  fsm_d      = TAIL;
               end
            end
         end
         TAIL: begin
            if (load_ok_c) begin
               load_c     = 1'b1;
               tail_cnt_d = tail_cnt_q + TW'(1);
               if (tail_cnt_q == TW'(K - 2)) begin
                  load_last_c = 1'b1;
                  tail_cnt_d  = '0;
                  fsm_d       = DONE;
               end
            end
         end
         DONE: begin
            if (out_valid_q && out_ready_i && out_last_q) begin
               busy_d = 1'b0;
               fsm_d  = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase

      w_c   = {enc_bit_c, enc_state_c};
      sym_c = {^(w_c & G1), ^(w_c & G0)};

      if (load_c) begin
         out_valid_d = 1'b1;
`ifdef CONV_ENC_ERR_INJ_EN
         out_pair_d  = sym_c ^ err_mask_i;
`else
         out_pair_d  = sym_c;
`endif
         out_last_d  = load_last_c;
         state_d     = w_c[K-1:1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_pair_q  <= 2'b00;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         out_pair_q  <= out_pair_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         armed_q     <= 1'b1;
      end
   end

   assign in_ready_o  = in_ready_c;
   assign out_valid_o = out_valid_q;
   assign out_pair_o  = out_pair_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Scoreboard bench for conv_encoder_k7: directed frames push expected symbols, a monitor pops on handshake.
module tb_conv_encoder_k7;

   localparam logic [6:0] G0 = 7'o171;
   localparam logic [6:0] G1 = 7'o133;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_bit, in_last;
   logic       in_ready_o;
   logic       out_valid_o;
   logic [1:0] out_pair_o;
   logic       out_last_o;
   logic       out_ready;
   logic       busy_o;
   logic [1:0] err_mask;

   conv_encoder_k7 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_bit_i    (in_bit),
      .in_last_i   (in_last),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_pair_o  (out_pair_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready),
`ifdef CONV_ENC_ERR_INJ_EN
      .err_mask_i  (err_mask),
`endif
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] pair;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   int         checks   = 0;
   int         errors   = 0;
   int         sym_cnt  = 0;
   int         rdy_mode = 0;
   logic [1:0] imp [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_impulse(input logic [1:0] first_flip);
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         e.pair = imp[i] ^ ((i == 0) ? first_flip : 2'b00);
         e.last = (i == 6);
         exp_q.push_back(e);
      end
   endtask

   // Software golden encoder; bits[n-1] is sent first
   task automatic push_model(input logic [31:0] bits, input int n);
      logic [5:0] st;
      logic [6:0] w;
      logic       b;
      exp_t       e;
      st = '0;
      for (int i = 0; i < n + 6; i++) begin
         b      = (i < n) ? bits[n-1-i] : 1'b0;
         w      = {b, st};
         e.pair = {^(w & G1), ^(w & G0)};
         e.last = (i == n + 5);
         exp_q.push_back(e);
         st = w[6:1];
      end
   endtask

   task automatic drive_bit(input logic b, input logic last);
      int cyc;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = last;
      cyc      = 0;
      forever begin
         @(negedge clk);
         if (in_ready_o) begin
            @(posedge clk);
            #1;
            break;
         end
         cyc++;
         if (cyc > 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         drive_bit(bits[n-1-i], i == n - 1);
         if (i == 0) chk("busy_after_first_accept", 32'(busy_o), 32'd1);
      end
   endtask

   task automatic wait_done(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc > 500) begin
            chk({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
      chk({name, "_busy_end"}, 32'(busy_o), 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: checks stall stability and pops the scoreboard on every handshake
   logic       held_v = 1'b0;
   logic [2:0] held;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v) chk("stall_stable", {28'd0, out_valid_o, out_pair_o, out_last_o}, {28'd0, 1'b1, held});
         if (out_valid_o && out_ready) begin
            sym_cnt++;
            held_v = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_symbol", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_pair", 32'(out_pair_o), 32'(e.pair));
               chk("out_last", 32'(out_last_o), 32'(e.last));
            end
         end else if (out_valid_o) begin
            held_v = 1'b1;
            held   = {out_pair_o, out_last_o};
         end else begin
            held_v = 1'b0;
         end
      end
   end

   initial begin
      int base;
      int lowcnt;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      err_mask  = 2'b00;
      #12;
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_pair", 32'(out_pair_o), 32'd0);
      chk("rst_out_last", 32'(out_last_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Impulse response
      push_impulse(2'b00);
      send_frame(32'd1, 1);
      wait_done("impulse");

      // All-zero 8-bit frame: in_ready low during the 6 tail loads
      push_model(32'd0, 8);
      send_frame(32'd0, 8);
      lowcnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (out_valid_o && out_ready && out_last_o) break;
         if (!in_ready_o) lowcnt++;
      end
      chk("zero_tail_ready_low", 32'(lowcnt), 32'd6);
      @(posedge clk);
      #1;
      chk("zero_ready_back", 32'(in_ready_o), 32'd1);
      wait_done("zero8");

      // Random backpressure over a 16-bit frame
      base     = sym_cnt;
      rdy_mode = 1;
      push_model(32'hB3C5, 16);
      send_frame(32'hB3C5, 16);
      wait_done("backpressure");
      rdy_mode = 0;
      chk("backpressure_count", 32'(sym_cnt - base), 32'd22);

      // Reset after 5 symbols, then impulse must be clean
      base = sym_cnt;
      push_model(32'b1101001110, 10);
      for (int i = 0; i < 10; i++) begin
         drive_bit(1'(32'b1101001110 >> (9 - i)), i == 9);
         if (sym_cnt - base >= 5) break;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_in_ready", 32'(in_ready_o), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      push_impulse(2'b00);
      send_frame(32'd1, 1);
      wait_done("post_reset_impulse");

      // Back-to-back frames A=1011 then B=1
      base = sym_cnt;
      push_model(32'b1011, 4);
      push_impulse(2'b00);
      send_frame(32'b1011, 4);
      send_frame(32'd1, 1);
      wait_done("back_to_back");
      chk("back_to_back_count", 32'(sym_cnt - base), 32'd17);

`ifdef CONV_ENC_ERR_INJ_EN
      // Error mask on the first load only
      push_impulse(2'b01);
      err_mask = 2'b01;
      drive_bit(1'b1, 1'b1);
      err_mask = 2'b00;
      wait_done("err_inj");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
